// File: rtl/window_scan_sequencer_pkg.sv
// Shared definitions for the window scan sequencer and its position stepper.
//   - Default screen/window geometry (network parameters)
//   - Sequencer state type
//   - window_fits(): whether a window of the given size fits on the screen at all
package window_scan_sequencer_pkg;

  localparam int unsigned NET_X_BITS   = 10;
  localparam int unsigned NET_Y_BITS   = 10;
  localparam int unsigned NET_SCREEN_W = 640;
  localparam int unsigned NET_SCREEN_H = 480;
  localparam int unsigned NET_BUFFER_W = 28;
  localparam int unsigned NET_BUFFER_H = 28;
  localparam int unsigned NET_STRIDE_X = 28;
  localparam int unsigned NET_STRIDE_Y = 28;
  localparam int unsigned NET_CNT_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_FILL,
    ST_LAUNCH,
    ST_COMPUTE,
    ST_HANDOFF,
    ST_ADVANCE
  } scan_state_t;

  function automatic logic window_fits(input int unsigned buf_w, input int unsigned buf_h,
                                       input int unsigned scr_w, input int unsigned scr_h);
    return (buf_w <= scr_w) && (buf_h <= scr_h);
  endfunction

endpackage

// File: rtl/window_scan_sequencer_window_pos_stepper.sv
// window_pos_stepper: combinational next window origin for a raster-order scan.
//   x_pos/y_pos   : current window origin
//   next_x/next_y : origin of the following window ((0,0) after the last one)
//   last_window   : current window is the final one of the frame (always set
//                   when the window does not fit on the screen at all)
module window_pos_stepper
  import window_scan_sequencer_pkg::*;
#(
  parameter int unsigned X_BITS   = NET_X_BITS,
  parameter int unsigned Y_BITS   = NET_Y_BITS,
  parameter int unsigned SCREEN_W = NET_SCREEN_W,
  parameter int unsigned SCREEN_H = NET_SCREEN_H,
  parameter int unsigned BUFFER_W = NET_BUFFER_W,
  parameter int unsigned BUFFER_H = NET_BUFFER_H,
  parameter int unsigned STRIDE_X = NET_STRIDE_X,
  parameter int unsigned STRIDE_Y = NET_STRIDE_Y
) (
  input  logic [X_BITS-1:0] x_pos,
  input  logic [Y_BITS-1:0] y_pos,
  output logic [X_BITS-1:0] next_x,
  output logic [Y_BITS-1:0] next_y,
  output logic              last_window
);

  localparam int unsigned XB  = X_BITS;
  localparam int unsigned YB  = Y_BITS;
  localparam int unsigned XW  = X_BITS + 1;
  localparam int unsigned YW  = Y_BITS + 1;
  localparam logic        FITS = window_fits(BUFFER_W, BUFFER_H, SCREEN_W, SCREEN_H);

  // One extra bit so the far edge of the next window cannot wrap.
  localparam logic [XW-1:0] X_STEP_END = XW'(STRIDE_X + BUFFER_W);
  localparam logic [YW-1:0] Y_STEP_END = YW'(STRIDE_Y + BUFFER_H);
  localparam logic [XW-1:0] X_LIMIT    = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIMIT    = YW'(SCREEN_H);

  logic [XW-1:0] x_end;
  logic [YW-1:0] y_end;

  assign x_end = {1'b0, x_pos} + X_STEP_END;
  assign y_end = {1'b0, y_pos} + Y_STEP_END;

  always_comb begin
    next_x      = x_pos;
    next_y      = y_pos;
    last_window = 1'b0;
    if (!FITS) begin
      next_x      = '0;
      next_y      = '0;
      last_window = 1'b1;
    end else if (x_end <= X_LIMIT) begin
      next_x = x_pos + XB'(STRIDE_X);
    end else begin
      next_x = '0;
      if (y_end <= Y_LIMIT) begin
        next_y = y_pos + YB'(STRIDE_Y);
      end else begin
        next_y      = '0;
        last_window = 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_scan_sequencer.sv
// window_scan_sequencer: walks a window across the video frame, waits for the
// window controller to fill it, launches the mult-adder tree and hands each
// result downstream over a valid/ready handshake.
//   clock, reset            : system clock, synchronous active-high reset
//   start, abort            : begin a scan at (0,0) / return to idle at once
//   continuous              : restart automatically after the last window
//   screen_x, screen_y      : position of the current stream pixel
//   buffer_rdy              : window controller reports the buffer full
//   tree_done               : mult-adder tree result ready (pulse)
//   win_ready               : downstream accepts the window result
//   buffer_x_pos/_y_pos     : window origin driven to the window controller
//   tree_start              : one-cycle launch pulse to the tree
//   win_valid               : window result available downstream
//   busy, scan_done         : not idle / last window accepted (pulse)
//   window_count            : windows accepted since the last start
module window_scan_sequencer
  import window_scan_sequencer_pkg::*;
#(
  parameter int unsigned X_BITS   = NET_X_BITS,
  parameter int unsigned Y_BITS   = NET_Y_BITS,
  parameter int unsigned SCREEN_W = NET_SCREEN_W,
  parameter int unsigned SCREEN_H = NET_SCREEN_H,
  parameter int unsigned BUFFER_W = NET_BUFFER_W,
  parameter int unsigned BUFFER_H = NET_BUFFER_H,
  parameter int unsigned STRIDE_X = NET_STRIDE_X,
  parameter int unsigned STRIDE_Y = NET_STRIDE_Y,
  parameter int unsigned CNT_BITS = NET_CNT_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [X_BITS-1:0]   screen_x,
  input  logic [Y_BITS-1:0]   screen_y,
  input  logic                buffer_rdy,
  input  logic                tree_done,
  input  logic                win_ready,
  output logic [X_BITS-1:0]   buffer_x_pos,
  output logic [Y_BITS-1:0]   buffer_y_pos,
  output logic                tree_start,
  output logic                win_valid,
  output logic                busy,
  output logic                scan_done,
  output logic [CNT_BITS-1:0] window_count
);

  localparam logic WIN_FITS = window_fits(BUFFER_W, BUFFER_H, SCREEN_W, SCREEN_H);

  scan_state_t       state;
  logic              rdy_low_seen;
  logic [X_BITS-1:0] step_x;
  logic [Y_BITS-1:0] step_y;
  logic              step_last;

  window_pos_stepper #(
    .X_BITS   (X_BITS),
    .Y_BITS   (Y_BITS),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .BUFFER_W (BUFFER_W),
    .BUFFER_H (BUFFER_H),
    .STRIDE_X (STRIDE_X),
    .STRIDE_Y (STRIDE_Y)
  ) u_stepper (
    .x_pos       (buffer_x_pos),
    .y_pos       (buffer_y_pos),
    .next_x      (step_x),
    .next_y      (step_y),
    .last_window (step_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      rdy_low_seen <= 1'b0;
      buffer_x_pos <= '0;
      buffer_y_pos <= '0;
      tree_start   <= 1'b0;
      win_valid    <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
      window_count <= '0;
    end else if (abort) begin
      // window_count is deliberately kept so software can see progress.
      state        <= ST_IDLE;
      rdy_low_seen <= 1'b0;
      buffer_x_pos <= '0;
      buffer_y_pos <= '0;
      tree_start   <= 1'b0;
      win_valid    <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      tree_start <= 1'b0;
      scan_done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          buffer_x_pos <= '0;
          buffer_y_pos <= '0;
          if (start) begin
            window_count <= '0;
            busy         <= 1'b1;
            // A window that cannot fit is never launched: finish straight away.
            state        <= WIN_FITS ? ST_WAIT_FRAME : ST_ADVANCE;
          end
        end
        ST_WAIT_FRAME: begin
          if (screen_x == '0 && screen_y == '0) begin
            rdy_low_seen <= 1'b0;
            state        <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Require a low on buffer_rdy first so a level left over from the
          // previous window cannot launch the tree.
          if (!buffer_rdy) begin
            rdy_low_seen <= 1'b1;
          end else if (rdy_low_seen) begin
            tree_start <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (tree_done) begin
            win_valid <= 1'b1;
            state     <= ST_HANDOFF;
          end
        end
        ST_HANDOFF: begin
          if (win_ready) begin
            win_valid    <= 1'b0;
            window_count <= window_count + 1'b1;
            state        <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          buffer_x_pos <= step_x;
          buffer_y_pos <= step_y;
          if (step_last) begin
            scan_done <= 1'b1;
            if (continuous && WIN_FITS) begin
              window_count <= '0;
              state        <= ST_WAIT_FRAME;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_WAIT_FRAME;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_scan_sequencer.sv
module tb_window_scan_sequencer;

  localparam int unsigned SW = 8;
  localparam int unsigned SH = 6;
  localparam int unsigned BW = 3;
  localparam int unsigned BH = 3;
  localparam int unsigned SX = 3;
  localparam int unsigned SY = 3;
  localparam int unsigned RAST_W = 10;
  localparam int unsigned RAST_H = 8;

  logic        clock = 1'b0;
  logic        reset, start, start2, abort, continuous;
  logic [9:0]  screen_x, screen_y;
  logic        buffer_rdy, tree_done, win_ready;

  logic [9:0]  buffer_x_pos, buffer_y_pos;
  logic        tree_start, win_valid, busy, scan_done;
  logic [15:0] window_count;

  logic [9:0]  buffer_x_pos2, buffer_y_pos2;
  logic        tree_start2, win_valid2, busy2, scan_done2;
  logic [15:0] window_count2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_tree_start = 0, n_scan_done = 0, n_tree_start2 = 0;
  int unsigned exp_x[$], exp_y[$];
  logic [15:0] exp_count;

  always #5 clock = ~clock;

  window_scan_sequencer #(
    .SCREEN_W (SW), .SCREEN_H (SH), .BUFFER_W (BW), .BUFFER_H (BH),
    .STRIDE_X (SX), .STRIDE_Y (SY)
  ) dut (
    .clock (clock), .reset (reset), .start (start), .abort (abort),
    .continuous (continuous), .screen_x (screen_x), .screen_y (screen_y),
    .buffer_rdy (buffer_rdy), .tree_done (tree_done), .win_ready (win_ready),
    .buffer_x_pos (buffer_x_pos), .buffer_y_pos (buffer_y_pos),
    .tree_start (tree_start), .win_valid (win_valid), .busy (busy),
    .scan_done (scan_done), .window_count (window_count)
  );

  window_scan_sequencer #(
    .SCREEN_W (SW), .SCREEN_H (SH), .BUFFER_W (10), .BUFFER_H (BH),
    .STRIDE_X (SX), .STRIDE_Y (SY)
  ) dut_nofit (
    .clock (clock), .reset (reset), .start (start2), .abort (abort),
    .continuous (continuous), .screen_x (screen_x), .screen_y (screen_y),
    .buffer_rdy (buffer_rdy), .tree_done (tree_done), .win_ready (win_ready),
    .buffer_x_pos (buffer_x_pos2), .buffer_y_pos (buffer_y_pos2),
    .tree_start (tree_start2), .win_valid (win_valid2), .busy (busy2),
    .scan_done (scan_done2), .window_count (window_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock: observe outputs at the falling edge, then move the raster.
  task automatic step();
    @(negedge clock);
    if (tree_start)  n_tree_start++;
    if (scan_done)   n_scan_done++;
    if (tree_start2) n_tree_start2++;
    if (screen_x == 10'(RAST_W - 1)) begin
      screen_x = '0;
      screen_y = (screen_y == 10'(RAST_H - 1)) ? 10'd0 : screen_y + 10'd1;
    end else begin
      screen_x = screen_x + 10'd1;
    end
  endtask

  task automatic wait_frame_and_fill(input int unsigned idx);
    int unsigned guard;
    int unsigned ts_before;
    repeat (3) step();
    guard = 0;
    while (!(screen_x == 0 && screen_y == 0) && guard < 200) begin
      step();
      guard++;
    end
    chk("frame_sync_bound", 32'(guard < 200), 1);
    ts_before = n_tree_start;
    buffer_rdy = 1'b1;
    repeat (2 + $urandom_range(0, 4)) begin
      tree_done = ($urandom_range(0, 3) == 0);
      step();
    end
    tree_done = 1'b0;
    chk("stale_rdy_no_launch", n_tree_start - ts_before, 0);
    chk("stray_done_no_valid", win_valid, 0);
    buffer_rdy = 1'b0;
    repeat ($urandom_range(1, 3)) step();
    buffer_rdy = 1'b1;
    step();
    chk("launch_latency", tree_start, 1);
    chk("launch_pos_x", buffer_x_pos, exp_x[idx]);
    chk("launch_pos_y", buffer_y_pos, exp_y[idx]);
    step();
    chk("tree_start_one_cycle", tree_start, 0);
  endtask

  task automatic compute_and_handoff(input int unsigned idx, input bit last,
                                     input bit cont, input int bp_force);
    int unsigned bp;
    int unsigned hi;
    repeat ($urandom_range(0, 4)) begin
      step();
      chk("compute_no_valid", win_valid, 0);
    end
    tree_done = 1'b1;
    step();
    tree_done = 1'b0;
    chk("valid_after_done", win_valid, 1);
    bp = (bp_force >= 0) ? int'(bp_force) : $urandom_range(0, 5);
    hi = 1;
    win_ready = 1'b0;
    repeat (bp) begin
      step();
      hi += 32'(win_valid);
      chk("bp_hold_x", buffer_x_pos, exp_x[idx]);
      chk("bp_count_held", window_count, exp_count);
    end
    chk("valid_high_cycles", hi, bp + 1);
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk("valid_drop", win_valid, 0);
    chk("count_inc", window_count, exp_count);
    step();
    chk("scan_done_pulse", scan_done, 32'(last));
    if (last) begin
      chk("end_pos_x", buffer_x_pos, 0);
      chk("end_pos_y", buffer_y_pos, 0);
      if (cont) begin
        exp_count = '0;
        chk("cont_count_clear", window_count, 0);
        chk("cont_busy", busy, 1);
      end else begin
        chk("end_idle", busy, 0);
        chk("end_count", window_count, exp_count);
      end
    end else begin
      chk("next_pos_x", buffer_x_pos, exp_x[idx + 1]);
      chk("next_pos_y", buffer_y_pos, exp_y[idx + 1]);
    end
  endtask

  task automatic run_scan(input bit cont, input int first_bp);
    int unsigned sd0;
    continuous = cont;
    buffer_rdy = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_count = '0;
    chk("start_busy", busy, 1);
    chk("start_clears_count", window_count, 0);
    sd0 = n_scan_done;
    for (int unsigned i = 0; i < exp_x.size(); i++) begin
      wait_frame_and_fill(i);
      if (i == 2) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_while_busy", busy, 1);
      end
      compute_and_handoff(i, i == exp_x.size() - 1, cont, (i == 0) ? first_bp : -1);
    end
    chk("one_scan_done", n_scan_done - sd0, 1);
  endtask

  initial begin
    int unsigned sd0;
    for (int unsigned y = 0; y + BH <= SH; y += SY)
      for (int unsigned x = 0; x + BW <= SW; x += SX) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end

    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; continuous = 1'b0;
    screen_x = '0; screen_y = '0; buffer_rdy = 1'b0; tree_done = 1'b0; win_ready = 1'b0;
    exp_count = '0;
    repeat (3) step();
    chk("rst_pos_x", buffer_x_pos, 0);
    chk("rst_pos_y", buffer_y_pos, 0);
    chk("rst_tree_start", tree_start, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_count", window_count, 0);
    reset = 1'b0;
    step();

    // Single scans with random timing; first window uses 5 cycles of backpressure.
    run_scan(1'b0, 5);
    repeat (4) step();
    chk("idle_after_scan", busy, 0);
    run_scan(1'b0, -1);

    // Abort during COMPUTE of the second window.
    continuous = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp_count = '0;
    wait_frame_and_fill(0);
    compute_and_handoff(0, 1'b0, 1'b0, -1);
    wait_frame_and_fill(1);
    sd0 = n_scan_done;
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pos_x", buffer_x_pos, 0);
    chk("abort_win_valid", win_valid, 0);
    chk("abort_tree_start", tree_start, 0);
    chk("abort_count_held", window_count, 1);
    tree_done = 1'b1; step(); tree_done = 1'b0;
    step();
    chk("late_done_ignored", win_valid, 0);
    chk("abort_no_scan_done", n_scan_done - sd0, 0);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    step();
    chk("start_abort_idle2", busy, 0);
    chk("start_abort_count", window_count, 1);

    // Continuous mode: the next frame starts again from (0,0).
    run_scan(1'b1, -1);
    wait_frame_and_fill(0);
    abort = 1'b1; step(); abort = 1'b0;
    continuous = 1'b0;
    chk("cont_abort_busy", busy, 0);

    // Reset while a result waits in HANDOFF.
    start = 1'b1; step(); start = 1'b0;
    exp_count = '0;
    wait_frame_and_fill(0);
    compute_and_handoff(0, 1'b0, 1'b0, 0);
    wait_frame_and_fill(1);
    tree_done = 1'b1; step(); tree_done = 1'b0;
    chk("handoff_valid", win_valid, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("hrst_pos_x", buffer_x_pos, 0);
    chk("hrst_win_valid", win_valid, 0);
    chk("hrst_busy", busy, 0);
    chk("hrst_count", window_count, 0);
    chk("hrst_tree_start", tree_start, 0);
    chk("hrst_scan_done", scan_done, 0);

    // Window wider than the screen: finishes without any launch.
    start2 = 1'b1; step(); start2 = 1'b0;
    chk("nofit_busy", busy2, 1);
    step();
    chk("nofit_scan_done", scan_done2, 1);
    chk("nofit_idle", busy2, 0);
    step();
    chk("nofit_done_pulse", scan_done2, 0);
    chk("nofit_no_launch", n_tree_start2, 0);
    chk("nofit_count", window_count2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
